aucohl_fifo_th: RTL and testbench
=================================

AUCOHL_FIFO_TH -- requirements
Module: aucohl_fifo_th

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter AW, default 4, address width; DEPTH = 2**AW entries.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  synchronous empty request.
REQ-006 SHALL have ports wr  input  1  write request, and wdata  input  DW  write data.
REQ-007 SHALL have ports rd  input  1  read/pop request, and rdata  output  DW  head-of-queue data.
REQ-008 SHALL have ports full, empty  output  1 each  registered occupancy flags.
REQ-009 SHALL have port level  output  AW+1  current occupancy, 0..DEPTH inclusive.
REQ-010 SHALL have ports afull_th, aempty_th  input  AW+1 each  programmable thresholds.
REQ-011 SHALL have ports afull, aempty  output  1 each  threshold flags.
REQ-012 SHALL have ports overflow, underflow  output  1 each, and err_clr  input  1  sticky error flags and their clear.

Function
REQ-013 SHALL accept a write iff wr=1 and full=0; the accepted word is stored at the write pointer on that edge.
REQ-014 SHALL accept a read iff rd=1 and empty=0; the read pointer advances on that edge.
REQ-015 SHALL present rdata as the head entry (show-ahead, zero-latency); rdata is don't-care while empty=1.
REQ-016 SHALL update level by +1 on write-only, -1 on read-only, 0 on both or neither accepted.
REQ-017 SHALL, when full=1 and wr=rd=1: accept the read, reject the write; next level = DEPTH-1.
REQ-018 SHALL, when empty=1 and wr=rd=1: accept the write, reject the read; next level = 1, rdata = wdata on the next cycle.
REQ-019 SHALL wrap read/write pointers modulo DEPTH without skipping entries.
REQ-020 SHALL register full (level==DEPTH) and empty (level==0) so both are consistent with level every cycle.
REQ-021 SHALL drive afull = (level >= afull_th) and aempty = (level <= aempty_th), combinationally from registered level; thresholds sampled every cycle.
REQ-022 SHALL, on flush=1, set pointers and level to 0, empty=1, full=0 on that edge; wr and rd ignored in that cycle; memory contents not cleared.
REQ-023 SHALL set overflow on the edge where wr=1 and full=1, and underflow where rd=1 and empty=1 (including REQ-017/018 cases).
REQ-024 SHALL hold overflow/underflow until err_clr=1; a set condition in the same cycle as err_clr wins.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set pointers=0, level=0, empty=1, full=0, overflow=0, underflow=0.
REQ-026 SHALL give rst priority over flush, wr, rd and err_clr; reset mid-operation discards all stored words.
REQ-027 SHALL not reset the storage array.

Configuration
REQ-028 SHALL compile sticky error logic (REQ-023/024) only when AUCOHL_FIFO_ERR_FLAGS_EN is defined.
REQ-029 SHALL, without AUCOHL_FIFO_ERR_FLAGS_EN, keep overflow/underflow/err_clr ports, drive overflow=underflow=0, ignore err_clr; all other behaviour identical.

Structure
REQ-030 SHALL take shared constants (default DW/AW, DEPTH function, default thresholds) from shared package aucohl_pkg.
REQ-031 SHALL instantiate storage as sub-module aucohl_ram_1r1w (sync write, async read, DW x DEPTH); control logic stays in aucohl_fifo_th.

Verification (DW=8, AW=2, DEPTH=4, afull_th=3, aempty_th=1, macro defined)
REQ-032 SHALL cover: rst; write 0xA1,0xB2,0xC3,0xD4 -> level 1,2,3,4; afull at level 3; full=1 after 4th; rdata=0xA1 throughout.
REQ-033 SHALL cover: full, wr=1 with 0xEE -> write rejected, overflow=1, level stays 4; 4 reads return A1,B2,C3,D4 then empty=1.
REQ-034 SHALL cover: empty, wr=rd=1 with 0x55 -> level=1, underflow=1, rdata=0x55; err_clr=1 -> underflow=0 next cycle.
REQ-035 SHALL cover: 10 interleaved write/read pairs at level 2 -> pointers wrap, level stays 2, data order preserved.
REQ-036 SHALL cover: level 3, flush=1 with wr=1 -> level=0, empty=1, aempty=1, written word dropped; rst with flush -> all flags reset values.

Source files
------------

// File: rtl/aucohl_pkg.sv
// Shared constants and types for the aucohl FIFO family.
package aucohl_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 4;

  // Number of entries addressed by an aw-bit pointer.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Default thresholds for a DEF_AW-deep FIFO: almost-full one entry short of
  // full, almost-empty at a quarter of the depth.
  localparam int DEF_AFULL_TH  = depth_of(DEF_AW) - 1;
  localparam int DEF_AEMPTY_TH = depth_of(DEF_AW) / 4;

  // Accepted operation in one cycle, encoded as {write_ok, read_ok}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/aucohl_ram_1r1w.sv
// Simple dual-port storage: synchronous write, asynchronous (show-ahead) read.
// The array is never reset; contents survive reset and flush.
module aucohl_ram_1r1w #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [0:DEPTH-1];

  // Store the write word at the write address on each enabled edge.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/aucohl_fifo_th.sv
// Synchronous show-ahead FIFO with occupancy level, programmable
// almost-full / almost-empty thresholds and optional sticky error flags.
// Define AUCOHL_FIFO_ERR_FLAGS_EN to build the overflow/underflow logic;
// otherwise those outputs are tied low and err_clr is ignored.
module aucohl_fifo_th
  import aucohl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  input  logic [AW:0]   afull_th,
  input  logic [AW:0]   aempty_th,
  output logic          afull,
  output logic          aempty,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr
);

  localparam int          DEPTH    = depth_of(AW);
  localparam int          LW       = AW + 1;
  localparam logic [AW:0] LVL_FULL = LW'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_full;
  logic          r_empty;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_ram_we;
  fifo_op_e      w_op;
  logic [AW:0]   w_level_next;

  // Decide which requests are accepted and the resulting occupancy.
  always_comb begin
    w_wr_ok      = wr & ~r_full;
    w_rd_ok      = rd & ~r_empty;
    w_op         = fifo_op_e'({w_wr_ok, w_rd_ok});
    w_level_next = r_level;
    case (w_op)
      OP_WR:   w_level_next = r_level + 1'b1;
      OP_RD:   w_level_next = r_level - 1'b1;
      default: w_level_next = r_level;
    endcase
  end

  // Pointers, level and flags; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_FULL);
      r_empty <= (w_level_next == '0);
    end
  end

  // A write ignored because of reset or flush must not touch storage.
  assign w_ram_we = w_wr_ok & ~flush & ~rst;

  aucohl_ram_1r1w #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wptr),
    .wdata (wdata),
    .raddr (r_rptr),
    .rdata (rdata)
  );

  assign level  = r_level;
  assign full   = r_full;
  assign empty  = r_empty;
  assign afull  = (r_level >= afull_th);
  assign aempty = (r_level <= aempty_th);

`ifdef AUCOHL_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr && r_full && !flush) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (rd && r_empty && !flush) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_aucohl_fifo_th.sv
// Self-checking bench for aucohl_fifo_th (DW=8, AW=2) against a queue model.
module tb_aucohl_fifo_th;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef AUCOHL_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] rdata;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic [AW:0]   afull_th = 3'd3;
  logic [AW:0]   aempty_th = 3'd1;
  logic          afull;
  logic          aempty;
  logic          overflow;
  logic          underflow;
  logic          err_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Reference model: a plain queue of stored words plus two sticky bits.
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  aucohl_fifo_th #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr        (wr),
    .wdata     (wdata),
    .rd        (rd),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .afull_th  (afull_th),
    .aempty_th (aempty_th),
    .afull     (afull),
    .aempty    (aempty),
    .overflow  (overflow),
    .underflow (underflow),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model, wait past the edge.
  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f, input bit ec, input bit rs);
    bit was_full;
    bit was_empty;
    wr = w; wdata = d; rd = r; flush = f; err_clr = ec; rst = rs;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (ERR_EN) begin
        if (w && was_full && !f) m_ovf = 1'b1;
        else if (ec) m_ovf = 1'b0;
        if (r && was_empty && !f) m_unf = 1'b1;
        else if (ec) m_unf = 1'b0;
      end
      if (f) begin
        q.delete();
      end else begin
        if (r && !was_empty) void'(q.pop_front());
        if (w && !was_full) q.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0; rst = 1'b0;
    txn++;
    $display("txn %0d: rst=%0b flush=%0b wr=%0b wd=%02h rd=%0b clr=%0b -> level=%0d full=%0b empty=%0b rdata=%02h ovf=%0b unf=%0b",
             txn, rs, f, w, d, r, ec, level, full, empty, rdata, overflow, underflow);
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 0, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 0, 1);
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%02b exp=00", {overflow, underflow}); end
    total++; if ({afull, aempty} !== 2'b01) begin bad++; $display("FAIL reset_thr got=%02b exp=01", {afull, aempty}); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4];
    vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      drive(1, vals[i], 0, 0, 0, 0);
      total++; if (level !== 3'(i + 1)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", level, i + 1); end
      total++; if (rdata !== 8'hA1) begin bad++; $display("FAIL fill_rdata got=%02h exp=a1", rdata); end
      total++; if (afull !== (i + 1 >= 3)) begin bad++; $display("FAIL fill_afull got=%0b exp=%0b", afull, (i + 1 >= 3)); end
      total++; if (full !== (i == 3)) begin bad++; $display("FAIL fill_full got=%0b exp=%0b", full, (i == 3)); end
    end
  endtask

  task automatic test_overflow_drain();
    logic [DW-1:0] vals [4];
    vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    drive(1, 8'hEE, 0, 0, 0, 0);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
    total++; if (overflow !== ERR_EN) begin bad++; $display("FAIL ovf_flag got=%0b exp=%0b", overflow, ERR_EN); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rdata !== vals[i]) begin bad++; $display("FAIL drain_rdata got=%02h exp=%02h", rdata, vals[i]); end
      drive(0, 8'h00, 1, 0, 0, 0);
    end
    total++; if (empty !== 1'b1 || level !== 3'd0) begin bad++; $display("FAIL drain_empty got=%0b/%0d exp=1/0", empty, level); end
  endtask

  task automatic test_empty_rw();
    drive(1, 8'h55, 1, 0, 0, 0);
    total++; if (level !== 3'd1) begin bad++; $display("FAIL erw_level got=%0d exp=1", level); end
    total++; if (underflow !== ERR_EN) begin bad++; $display("FAIL erw_unf got=%0b exp=%0b", underflow, ERR_EN); end
    total++; if (rdata !== 8'h55) begin bad++; $display("FAIL erw_rdata got=%02h exp=55", rdata); end
    drive(0, 8'h00, 0, 0, 1, 0);
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL errclr got=%02b exp=00", {overflow, underflow}); end
  endtask

  task automatic test_interleave();
    logic [DW-1:0] d;
    drive(1, 8'h10, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      drive(1, d, 1, 0, 0, 0);
      total++; if (level !== 3'd2) begin bad++; $display("FAIL ilv_level got=%0d exp=2", level); end
      total++; if (rdata !== q[0]) begin bad++; $display("FAIL ilv_rdata got=%02h exp=%02h", rdata, q[0]); end
    end
  endtask

  task automatic test_flush();
    drive(1, 8'h33, 0, 0, 0, 0);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL pre_flush_level got=%0d exp=3", level); end
    drive(1, 8'h77, 0, 1, 0, 0);
    total++; if (level !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL flush_state got=%0d/%0b/%0b exp=0/1/0", level, empty, full); end
    total++; if (aempty !== 1'b1) begin bad++; $display("FAIL flush_aempty got=%0b exp=1", aempty); end
    drive(1, 8'h88, 0, 0, 0, 0);
    total++; if (rdata !== 8'h88 || level !== 3'd1) begin bad++; $display("FAIL post_flush got=%02h/%0d exp=88/1", rdata, level); end
    for (int i = 0; i < 4; i++) drive(1, 8'(i), 0, 0, 0, 0);
    total++; if (overflow !== ERR_EN) begin bad++; $display("FAIL pre_rst_ovf got=%0b exp=%0b", overflow, ERR_EN); end
    drive(1, 8'h99, 1, 1, 1, 1);
    total++; if ({level, empty, full, overflow, underflow} !== {3'd0, 4'b1000}) begin
      bad++; $display("FAIL rst_flush got=%0d/%0b/%0b/%0b/%0b exp=0/1/0/0/0", level, empty, full, overflow, underflow);
    end
  endtask

  task automatic test_random();
    bit w, r, f, ec;
    for (int i = 0; i < 300; i++) begin
      afull_th  = 3'($urandom_range(0, 4));
      aempty_th = 3'($urandom_range(0, 4));
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      f  = ($urandom_range(0, 99) < 4);
      ec = ($urandom_range(0, 99) < 10);
      drive(w, 8'($urandom_range(0, 255)), r, f, ec, 0);
      total++; if (level !== 3'(q.size())) begin bad++; $display("FAIL rnd_level got=%0d exp=%0d", level, q.size()); end
      total++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        bad++; $display("FAIL rnd_flags got=%0b%0b exp=%0b%0b", full, empty, (q.size() == DEPTH), (q.size() == 0));
      end
      total++; if (afull !== (q.size() >= int'(afull_th)) || aempty !== (q.size() <= int'(aempty_th))) begin
        bad++; $display("FAIL rnd_thr got=%0b%0b exp=%0b%0b", afull, aempty, (q.size() >= int'(afull_th)), (q.size() <= int'(aempty_th)));
      end
      total++; if ({overflow, underflow} !== {m_ovf, m_unf}) begin
        bad++; $display("FAIL rnd_err got=%0b%0b exp=%0b%0b", overflow, underflow, m_ovf, m_unf);
      end
      if (q.size() != 0) begin
        total++; if (rdata !== q[0]) begin bad++; $display("FAIL rnd_rdata got=%02h exp=%02h", rdata, q[0]); end
      end
    end
    afull_th  = 3'd3;
    aempty_th = 3'd1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_empty_rw();
    test_interleave();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
